// File: rtl/seq_divider_pkg.sv
// Shared definitions for the multi-cycle restoring divider: FSM encoding,
// default operand width and the divide-by-zero quotient pattern.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;

    // Wide enough for any supported WIDTH; users slice off the low bits.
    localparam logic [127:0] DBZ_ONES = '1;

endpackage

// File: rtl/seq_divider_subtractor_nbit.sv
// N-bit a - b on zero-extended operands: o_diff carries the low N-1 bits and
// o_borrow is the result MSB, i.e. the borrow when the operands' true values fit.
module subtractor_nbit
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = DEF_WIDTH + 1
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-2:0] o_diff,
    output logic         o_borrow
);

    localparam int unsigned NS = (N + 3) / 4;

    logic [N-2:0]  w_g;
    logic [N-2:0]  w_p;
    logic [N-1:0]  w_bi;
    logic [NS-1:0] w_bc;

    assign w_g     = ~i_a[N-2:0] & i_b[N-2:0];
    assign w_p     = ~(i_a[N-2:0] ^ i_b[N-2:0]);
    assign w_bc[0] = 1'b0;

    // 4-bit lookahead slices; bits beyond N-1 in the last slice are never built.
    for (genvar s = 0; s < NS; s++) begin : g_slice
        localparam int unsigned B = 4 * s;

        assign w_bi[B] = w_bc[s];

        if (B + 1 < N) begin : g_b1
            assign w_bi[B+1] = w_g[B] | (w_p[B] & w_bc[s]);
        end
        if (B + 2 < N) begin : g_b2
            assign w_bi[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                             | (w_p[B+1] & w_p[B] & w_bc[s]);
        end
        if (B + 3 < N) begin : g_b3
            assign w_bi[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                             | (w_p[B+2] & w_p[B+1] & w_g[B])
                             | (w_p[B+2] & w_p[B+1] & w_p[B] & w_bc[s]);
        end
        if (s < NS - 1) begin : g_bc
            assign w_bc[s+1] = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                             | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                             | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                             | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_bc[s]);
        end
    end

    assign o_diff   = i_a[N-2:0] ^ i_b[N-2:0] ^ w_bi[N-2:0];
    assign o_borrow = i_a[N-1] ^ i_b[N-1] ^ w_bi[N-1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for div/divu: one quotient bit per cycle on
// magnitudes, sign fix-up in a final cycle, one-cycle done pulse.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_den;
    logic             r_qsign;
    logic             r_rsign;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_div_zero;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag  = (dividend ^ {WIDTH{w_dvd_neg}}) + WIDTH'(w_dvd_neg);
    assign w_dvs_mag  = (divisor ^ {WIDTH{w_dvs_neg}}) + WIDTH'(w_dvs_neg);
    assign w_div_zero = (divisor == '0);

    assign w_shift = {r_rem, r_quo[WIDTH-1]};

    subtractor_nbit #(
        .N (WIDTH + 1)
    ) u_sub (
        .i_a      (w_shift),
        .i_b      ({1'b0, r_den}),
        .o_diff   (w_trial),
        .o_borrow (w_borrow)
    );

    // Conditional invert plus increment: one adder serves both signs.
    assign w_q_fix = (r_quo ^ {WIDTH{r_qsign}}) + WIDTH'(r_qsign);
    assign w_r_fix = (r_rem ^ {WIDTH{r_rsign}}) + WIDTH'(r_rsign);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = w_div_zero ? S_DONE : S_DIV;
            S_DIV:  if (r_count == CW'(1)) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_DIV, S_FIX: busy = 1'b1;
            S_DONE:       done = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_den       <= '0;
            r_qsign     <= 1'b0;
            r_rsign     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_div_zero) begin
                        r_quotient  <= DBZ_ONES[WIDTH-1:0];
                        r_remainder <= dividend;
                        r_dbz       <= 1'b1;
                    end else if (start) begin
                        r_quo   <= w_dvd_mag;
                        r_den   <= w_dvs_mag;
                        r_rem   <= '0;
                        r_qsign <= w_dvd_neg ^ w_dvs_neg;
                        r_rsign <= w_dvd_neg;
                        r_count <= CW'(WIDTH);
                    end
                end
                S_DIV: begin
                    r_rem   <= w_borrow ? w_shift[WIDTH-1:0] : w_trial;
                    r_quo   <= {r_quo[WIDTH-2:0], ~w_borrow};
                    r_count <= r_count - CW'(1);
                end
                S_FIX: begin
                    r_quotient  <= w_q_fix;
                    r_remainder <= w_r_fix;
                    r_dbz       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a per-cycle reference model built from plain signed /
// unsigned arithmetic and an edge-count latency, plus directed literal checks.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: language-level division truncates toward zero, remainder
    // follows the dividend's sign; the overflow case wraps to 0x80000000.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb, sq, sr;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[W-1:0];
            r  = sr[W-1:0];
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Model: 0 idle, 1 working (m_left edges until done), 2 done cycle.
    int           m_phase = 0;
    int           m_left = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_z = 1'b0, p_z = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0;
                m_left  = 0;
                m_q     = '0;
                m_r     = '0;
                m_z     = 1'b0;
            end
            check1("busy", busy, m_phase == 1);
            check1("done", done, m_phase == 2);
            check("quotient", quotient, m_q);
            check("remainder", remainder, m_r);
            check1("div_by_zero", div_by_zero, m_z);
            if (rst_n) begin
                case (m_phase)
                    0: if (start) begin
                        ref_div(dividend, divisor, is_signed, p_q, p_r, p_z);
                        if (divisor == '0) begin
                            m_phase = 2;
                            m_q = p_q; m_r = p_r; m_z = p_z;
                        end else begin
                            m_phase = 1;
                            m_left  = W + 1;
                        end
                    end
                    1: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = 2;
                            m_q = p_q; m_r = p_r; m_z = p_z;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(posedge clk); #1;
        start = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        check1("done_within_bound", done, 1'b1);
    endtask

    task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat, bc;
        issue(a, b, s);
        wait_done(lat, bc);
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check1({name, "_dbz"}, div_by_zero, 1'b0);
        check({name, "_latency"}, W'(lat), W'(W + 1));
    endtask

    initial begin
        int lat, bc;
        logic [W-1:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        check("reset_q", quotient, '0);
        check("reset_r", remainder, '0);
        check1("reset_busy", busy, 1'b0);
        rst_n = 1'b1;

        issue(32'd100, 32'd7, 1'b0);
        wait_done(lat, bc);
        check("divu_q", quotient, 32'd14);
        check("divu_r", remainder, 32'd2);
        check1("divu_dbz", div_by_zero, 1'b0);
        check("divu_latency", W'(lat), 32'd33);
        check("divu_busy_cycles", W'(bc), 32'd33);

        run_lit("neg7_div_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_lit("7_div_neg2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
        run_lit("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);

        issue(32'h1234, 32'd0, 1'b0);
        check1("dbz_done_next_cycle", done, 1'b1);
        check1("dbz_busy", busy, 1'b0);
        check("dbz_q", quotient, 32'hFFFF_FFFF);
        check("dbz_r", remainder, 32'h1234);
        check1("dbz_flag", div_by_zero, 1'b1);

        // Starts during DIV and on the DONE cycle are dropped; IDLE start is taken.
        issue(32'd1000, 32'd9, 1'b0);
        repeat (4) @(posedge clk);
        #1; start = 1'b1; dividend = 32'd5; divisor = 32'd1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(lat, bc);
        check("ignore_q", quotient, 32'd111);
        check("ignore_r", remainder, 32'd1);
        start = 1'b1; dividend = 32'd77; divisor = 32'd0; is_signed = 1'b0;
        @(posedge clk); #1;
        dividend = 32'd200; divisor = 32'd10;
        @(posedge clk); #1; start = 1'b0;
        wait_done(lat, bc);
        check("idle_start_q", quotient, 32'd20);
        check("idle_start_r", remainder, 32'd0);
        check("idle_start_latency", W'(lat), 32'd33);

        issue(32'd12345, 32'd67, 1'b0);
        repeat (9) @(posedge clk);
        #1; rst_n = 1'b0;
        #1;
        check("midreset_q", quotient, '0);
        check("midreset_r", remainder, '0);
        check1("midreset_busy", busy, 1'b0);
        check1("midreset_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        run_lit("after_reset", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : W'($urandom);
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                2:       b = -W'($urandom_range(1, 15));
                3:       b = '1;
                default: b = W'($urandom);
            endcase
            issue(a, b, 1'($urandom_range(0, 1)));
            wait_done(lat, bc);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle restoring divider for the MIPS datapath's `div`/`divu` instructions: the inverse of the adder path, with repeated shift-and-subtract in place of addition. It accepts a dividend/divisor pair with a start pulse and iterates one quotient bit per cycle. It then returns quotient (LO) and remainder (HI) with a one-cycle done pulse. It sits beside the ALU and is stalled on by the control unit while `busy` is high.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of 4.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `is_signed`  input  1  1 = `div` semantics, 0 = `divu`; sampled with `start`.
- `dividend`  input  WIDTH  numerator; sampled with `start`.
- `divisor`  input  WIDTH  denominator; sampled with `start`.
- `busy`  output  1  high from the cycle after an accepted start until the cycle `done` is high (exclusive).
- `done`  output  1  one-cycle pulse; results valid from this cycle onward.
- `quotient`  output  WIDTH  LO result; held until the next accepted start completes.
- `remainder`  output  WIDTH  HI result; held likewise.
- `div_by_zero`  output  1  qualifies the current results; valid with `done`, held with the results.

## Operation
- States: IDLE, DIV, FIX, DONE.
- IDLE, `start`=1, `divisor`≠0:
  - latch |dividend| and |divisor| (magnitudes only if `is_signed`);
  - latch quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend);
  - clear the partial remainder; counter ← WIDTH; go to DIV.
- IDLE, `start`=1, `divisor`=0:
  - go directly to DONE;
  - quotient ← all ones, remainder ← dividend (unmodified), `div_by_zero` ← 1.
- DIV, one step per cycle:
  - {R,Q} shifted left 1;
  - trial = R − D through the subtractor;
  - if there is no borrow, R ← trial and Q[0] ← 1, else Q[0] ← 0;
  - decrement the counter; at counter = 1 go to FIX.
- FIX:
  - quotient ← negated Q if the quotient sign is set, else Q;
  - remainder ← negated R if the remainder sign is set, else R;
  - `div_by_zero` ← 0; go to DONE.
- DONE: `done`=1 for this cycle only, then go to IDLE.
  - `start` here is ignored; it is accepted from the next IDLE cycle.
- `start` in DIV or FIX is ignored; there is no queueing.
- Signed overflow (−2^(WIDTH−1) / −1): quotient = 0x80000000, remainder = 0 (falls out of the magnitude path), `div_by_zero`=0.
- Arithmetic:
  - all magnitude and subtract operations are unsigned WIDTH+1 bits;
  - the borrow is the MSB of the WIDTH+1 result;
  - negation is two's complement (invert and add 1).

## Timing
- Reset (async, immediate on `rst_n`=0): state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, and all internal registers 0.
- Reset mid-operation aborts with no `done`.
- Start accepted at edge E0 (nonzero divisor):
  - DIV steps occur at edges E1..E_WIDTH;
  - FIX registers the results at E_WIDTH+1;
  - `done` is high for the cycle following E_WIDTH+1 (latency WIDTH+1 edges, i.e. 33 for WIDTH=32).
- Divide by zero: results and `done` are registered at E1 (latency 1).
- `busy` is high from E0 until the edge at which `done` rises.
- Minimum start-to-start spacing is WIDTH+3 cycles (WIDTH+1 latency, the DONE cycle, then the next IDLE).

## Structure
- Shared package/header holds:
  - state encodings (2-bit: IDLE=0, DIV=1, FIX=2, DONE=3);
  - the default WIDTH;
  - the all-ones divide-by-zero constant.
- One sub-module, `subtractor_nbit`:
  - WIDTH+1-bit a − b with a borrow-out;
  - built from 4-bit borrow-lookahead slices (generate = ~a&b, propagate = ~(a^b));
  - instantiated once for the trial subtraction.
- Negation is shared in FIX via a single incrementer path.

## Test plan
- `divu` 100 / 7 → `done` after 33 edges, quotient=14, remainder=2, `div_by_zero`=0, `busy` high for exactly 33 cycles.
- `div` −7 / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Also 7 / −2 → quotient=0xFFFFFFFD, remainder=1.
- Divide by zero: `divu` 0x1234 / 0 → `done` one cycle after start, quotient=0xFFFFFFFF, remainder=0x1234, `div_by_zero`=1.
- Overflow: `div` 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- `start` pulses during DIV and on the DONE cycle → ignored, results match the first operation. A start in the following IDLE cycle is accepted.
- `rst_n` low at DIV step 10 → all outputs 0 immediately, no `done`. A fresh 0xFFFFFFFF / 1 after release → quotient=0xFFFFFFFF, remainder=0.
